pipe_front_ctrl: RTL and testbench

//  Front-end pipeline sequencer for the 5-stage RV32I core. It owns the PC and the
//  ID/EX/M/WB instruction registers that feed the stall unit's instr_ID/instr_EX/instr_M

---
 rtl/pipe_front_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_front_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_front_ctrl.sv
// Front-end sequencer for the 5-stage RV32I core: owns the PC and ID/EX/M/WB instruction registers.
// Optional consecutive-stall watchdog enabled with `define STALL_WATCHDOG_EN.
module pipe_front_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter int unsigned WDOG_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_rdata,
    input  logic        keep_PC,
    input  logic        keep_instr,
    input  logic        nop_sel,
    input  logic        jb_taken,
    input  logic [31:0] jb_pc,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_IF,
    output logic [31:0] instr_ID,
    output logic [31:0] pc_ID,
    output logic [31:0] instr_EX,
    output logic [31:0] pc_EX,
    output logic [31:0] instr_M,
    output logic [31:0] instr_WB,
    output logic [31:0] stall_cnt,
    output logic        wdog_err
);

    logic [31:0] pc_if_q, pc_if_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] instr_ex_q, instr_ex_d;
    logic [31:0] pc_ex_q, pc_ex_d;
    logic [31:0] instr_m_q, instr_wb_q;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_evt;

    // A redirect in the same cycle cancels the stall, so it is not counted.
    assign stall_evt = keep_PC & ~jb_taken;

    always_comb begin
        pc_if_d     = pc_if_q + 32'd4;
        instr_id_d  = imem_rdata;
        pc_id_d     = pc_if_q;
        instr_ex_d  = instr_id_q;
        pc_ex_d     = pc_id_q;
        stall_cnt_d = stall_cnt_q;

        if (jb_taken) begin
            pc_if_d = jb_pc;
        end else if (keep_PC) begin
            pc_if_d = pc_if_q;
        end

        if (jb_taken) begin
            instr_id_d = NOP_INSTR;
            pc_id_d    = 32'd0;
        end else if (keep_instr) begin
            instr_id_d = instr_id_q;
            pc_id_d    = pc_id_q;
        end

        if (jb_taken || nop_sel) begin
            instr_ex_d = NOP_INSTR;
            pc_ex_d    = 32'd0;
        end

        if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_if_q     <= RESET_PC;
            instr_id_q  <= NOP_INSTR;
            pc_id_q     <= 32'd0;
            instr_ex_q  <= NOP_INSTR;
            pc_ex_q     <= 32'd0;
            instr_m_q   <= NOP_INSTR;
            instr_wb_q  <= NOP_INSTR;
            stall_cnt_q <= 32'd0;
        end else begin
            pc_if_q     <= pc_if_d;
            instr_id_q  <= instr_id_d;
            pc_id_q     <= pc_id_d;
            instr_ex_q  <= instr_ex_d;
            pc_ex_q     <= pc_ex_d;
            instr_m_q   <= instr_ex_q;
            instr_wb_q  <= instr_m_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef STALL_WATCHDOG_EN
    logic [15:0] run_q, run_d;
    logic        wdog_q, wdog_d;

    always_comb begin
        run_d  = 16'd0;
        wdog_d = wdog_q;
        if (stall_evt) begin
            // Hold at the top rather than wrap so a long stall cannot re-arm silently.
            run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
            if (run_d == 16'(WDOG_LIMIT)) begin
                wdog_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 16'd0;
            wdog_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            wdog_q <= wdog_d;
        end
    end

    assign wdog_err = wdog_q;
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign wdog_err          = 1'b0;
`endif

    assign imem_addr = pc_if_q;
    assign pc_IF     = pc_if_q;
    assign instr_ID  = instr_id_q;
    assign pc_ID     = pc_id_q;
    assign instr_EX  = instr_ex_q;
    assign pc_EX     = pc_ex_q;
    assign instr_M   = instr_m_q;
    assign instr_WB  = instr_wb_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Directed bench for pipe_front_ctrl: fetch latency, load-use stall, redirect, PC wrap, reset,
// and the stall watchdog when STALL_WATCHDOG_EN is defined.
module tb_pipe_front_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_rdata;
    logic        keep_PC, keep_instr, nop_sel, jb_taken;
    logic [31:0] jb_pc;
    logic [31:0] imem_addr, pc_IF, instr_ID, pc_ID, instr_EX, pc_EX, instr_M, instr_WB;
    logic [31:0] stall_cnt;
    logic        wdog_err;

    logic [31:0] mem [64];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[7:2]];

    pipe_front_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_rdata (imem_rdata),
        .keep_PC    (keep_PC),
        .keep_instr (keep_instr),
        .nop_sel    (nop_sel),
        .jb_taken   (jb_taken),
        .jb_pc      (jb_pc),
        .imem_addr  (imem_addr),
        .pc_IF      (pc_IF),
        .instr_ID   (instr_ID),
        .pc_ID      (pc_ID),
        .instr_EX   (instr_EX),
        .pc_EX      (pc_EX),
        .instr_M    (instr_M),
        .instr_WB   (instr_WB),
        .stall_cnt  (stall_cnt),
        .wdog_err   (wdog_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic kp, input logic ki, input logic ns, input logic jb,
                        input logic [31:0] tgt);
        keep_PC    = kp;
        keep_instr = ki;
        nop_sel    = ns;
        jb_taken   = jb;
        jb_pc      = tgt;
    endtask

    initial begin
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_8113;
        mem[2] = 32'h0000_A083;   // lw  x1,0(x1)
        mem[3] = 32'h0030_8133;   // add x2,x1,x3
        for (int i = 4; i < 64; i++) mem[i] = 32'h0A00_0000 + i;

        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        step();
        step();
        check("rst_pc_IF", pc_IF, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_instr_ID", instr_ID, NOP);
        check("rst_instr_EX", instr_EX, NOP);
        check("rst_instr_M", instr_M, NOP);
        check("rst_instr_WB", instr_WB, NOP);
        check("rst_pc_ID", pc_ID, 32'h0);
        check("rst_pc_EX", pc_EX, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
        check("rst_wdog", {31'd0, wdog_err}, 32'h0);

        // Straight-line fetch
        rst_n = 1'b1;
        step();
        check("f1_pc_IF", pc_IF, 32'h4);
        check("f1_instr_ID", instr_ID, 32'h0050_0093);
        check("f1_pc_ID", pc_ID, 32'h0);
        check("f1_instr_EX", instr_EX, NOP);
        step();
        check("f2_pc_IF", pc_IF, 32'h8);
        check("f2_instr_ID", instr_ID, 32'h0010_8113);
        check("f2_pc_ID", pc_ID, 32'h4);
        check("f2_instr_EX", instr_EX, 32'h0050_0093);
        step();
        check("f3_instr_M", instr_M, 32'h0050_0093);
        check("f3_instr_ID", instr_ID, 32'h0000_A083);
        step();
        check("f4_instr_WB", instr_WB, 32'h0050_0093);
        check("f4_pc_IF", pc_IF, 32'h10);
        check("f4_instr_ID", instr_ID, 32'h0030_8133);
        check("f4_instr_EX", instr_EX, 32'h0000_A083);
        check("f4_pc_EX", pc_EX, 32'h8);

        // Load-use: stall + bubble for one cycle
        ctrl(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("lu_pc_IF", pc_IF, 32'h10);
        check("lu_instr_ID", instr_ID, 32'h0030_8133);
        check("lu_pc_ID", pc_ID, 32'hC);
        check("lu_instr_EX", instr_EX, NOP);
        check("lu_pc_EX", pc_EX, 32'h0);
        check("lu_instr_M", instr_M, 32'h0000_A083);
        check("lu_stall_cnt", stall_cnt, 32'd1);
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check("lu2_pc_IF", pc_IF, 32'h14);
        check("lu2_instr_ID", instr_ID, 32'h0A00_0004);
        check("lu2_instr_EX", instr_EX, 32'h0030_8133);
        check("lu2_pc_EX", pc_EX, 32'hC);
        check("lu2_instr_M", instr_M, NOP);
        check("lu2_instr_WB", instr_WB, 32'h0000_A083);
        check("lu2_stall_cnt", stall_cnt, 32'd1);

        // Redirect while stalling: redirect wins, not counted as a stall
        ctrl(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
        step();
        check("rd_pc_IF", pc_IF, 32'h100);
        check("rd_instr_ID", instr_ID, NOP);
        check("rd_pc_ID", pc_ID, 32'h0);
        check("rd_instr_EX", instr_EX, NOP);
        check("rd_pc_EX", pc_EX, 32'h0);
        check("rd_instr_M", instr_M, 32'h0030_8133);
        check("rd_stall_cnt", stall_cnt, 32'd1);
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check("rd2_pc_IF", pc_IF, 32'h104);
        check("rd2_instr_ID", instr_ID, 32'h0050_0093);
        check("rd2_pc_ID", pc_ID, 32'h100);

        // PC wrap
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        check("wr_pc_IF", pc_IF, 32'hFFFF_FFFC);
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check("wr2_pc_IF", pc_IF, 32'h0);
        check("wr2_instr_ID", instr_ID, 32'h0A00_003F);
        check("wr2_pc_ID", pc_ID, 32'hFFFF_FFFC);

        // keep_PC alone: PC holds, fetched instr still enters ID
        ctrl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check("kp_pc_IF", pc_IF, 32'h0);
        check("kp_instr_ID", instr_ID, 32'h0050_0093);
        check("kp_instr_EX", instr_EX, 32'h0A00_003F);
        check("kp_stall_cnt", stall_cnt, 32'd2);

        // nop_sel alone: only EX is bubbled
        ctrl(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        check("ns_pc_IF", pc_IF, 32'h4);
        check("ns_instr_ID", instr_ID, 32'h0050_0093);
        check("ns_instr_EX", instr_EX, NOP);
        check("ns_stall_cnt", stall_cnt, 32'd2);

        // Mid-run reset at pc_IF=0x40
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 32'h3C);
        step();
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check("mr_pre_pc_IF", pc_IF, 32'h40);
        #2 rst_n = 1'b0;
        #1;
        check("mr_pc_IF", pc_IF, 32'h0);
        check("mr_instr_ID", instr_ID, NOP);
        check("mr_instr_EX", instr_EX, NOP);
        check("mr_instr_M", instr_M, NOP);
        check("mr_instr_WB", instr_WB, NOP);
        check("mr_stall_cnt", stall_cnt, 32'h0);
        step();
        rst_n = 1'b1;

        // Watchdog: 15-cycle run is tolerated, 16 trips it
        ctrl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) step();
        check("wd15_stall_cnt", stall_cnt, 32'd15);
        check("wd15_err", {31'd0, wdog_err}, 32'h0);
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check("wd15r_err", {31'd0, wdog_err}, 32'h0);
        ctrl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) step();
        check("wd31_err", {31'd0, wdog_err}, 32'h0);
        step();
        check("wd32_stall_cnt", stall_cnt, 32'd31);
`ifdef STALL_WATCHDOG_EN
        check("wd16_err", {31'd0, wdog_err}, 32'h1);
`else
        check("wd16_err", {31'd0, wdog_err}, 32'h0);
`endif
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step();
`ifdef STALL_WATCHDOG_EN
        check("wd_sticky", {31'd0, wdog_err}, 32'h1);
`else
        check("wd_sticky", {31'd0, wdog_err}, 32'h0);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("wd_rst_err", {31'd0, wdog_err}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_pc_IF", pc_IF, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
